// File: rtl/obstacle_scheduler.sv
// Obstacle stream generator for the runner game: two obstacle slots that scroll left
// once per frame, pseudo-random spawn gaps and types, and a registered nearest-obstacle view.
module obstacle_scheduler #(
    parameter int SPAWN_X  = 680,
    parameter int DX       = 5,
    parameter int GAP_INIT = 300,
    parameter int MIN_GAP  = 200,
    parameter int GAP_MASK = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic [1:0]  game_state,
    output logic        obs0_valid,
    output logic [10:0] obs0_x,
    output logic [1:0]  obs0_type,
    output logic        obs1_valid,
    output logic [10:0] obs1_x,
    output logic [1:0]  obs1_type,
    output logic        lead_valid,
    output logic [10:0] lead_x,
    output logic [7:0]  lead_w,
    output logic [6:0]  lead_h
);

    localparam logic [10:0] SPAWN_X_L  = 11'(SPAWN_X);
    localparam logic [10:0] DX_X       = 11'(DX);
    localparam logic [9:0]  DX_G       = 10'(DX);
    localparam logic [9:0]  GAP_INIT_L = 10'(GAP_INIT);
    localparam logic [9:0]  MIN_GAP_L  = 10'(MIN_GAP);
    localparam logic [7:0]  GAP_MASK_L = 8'(GAP_MASK);
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;

    function automatic logic [7:0] size_w(input logic [1:0] t);
        case (t)
            2'b00:   size_w = 8'd17;
            2'b01:   size_w = 8'd25;
            2'b10:   size_w = 8'd51;
            2'b11:   size_w = 8'd46;
            default: size_w = 8'd0;
        endcase
    endfunction

    function automatic logic [6:0] size_h(input logic [1:0] t);
        case (t)
            2'b00:   size_h = 7'd35;
            2'b01:   size_h = 7'd50;
            2'b10:   size_h = 7'd50;
            2'b11:   size_h = 7'd40;
            default: size_h = 7'd0;
        endcase
    endfunction

    logic [1:0]  valid_q, valid_d;
    logic [10:0] x_q [2];
    logic [10:0] x_d [2];
    logic [1:0]  type_q [2];
    logic [1:0]  type_d [2];
    logic [9:0]  gap_cnt_q, gap_cnt_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic        lead_valid_q, lead_valid_d;
    logic [10:0] lead_x_q, lead_x_d;
    logic [7:0]  lead_w_q, lead_w_d;
    logic [6:0]  lead_h_q, lead_h_d;
    logic [9:0]  gap_reload_s;

    assign gap_reload_s = MIN_GAP_L + {2'b00, lfsr_q[15:8] & GAP_MASK_L};

    // Next-state: free-running LFSR, slot movement/spawn and lead selection by game mode
    always_comb begin
        lfsr_d       = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        valid_d      = valid_q;
        x_d          = x_q;
        type_d       = type_q;
        gap_cnt_d    = gap_cnt_q;
        lead_valid_d = lead_valid_q;
        lead_x_d     = lead_x_q;
        lead_w_d     = lead_w_q;
        lead_h_d     = lead_h_q;
        case (game_state)
            2'b00: begin
                valid_d      = 2'b00;
                for (int i = 0; i < 2; i++) begin
                    x_d[i]    = 11'd0;
                    type_d[i] = 2'd0;
                end
                gap_cnt_d    = GAP_INIT_L;
                lead_valid_d = 1'b0;
                lead_x_d     = 11'h7FF;
                lead_w_d     = 8'd0;
                lead_h_d     = 7'd0;
            end
            2'b01: begin
                // Lead follows the slot registers; slot 0 wins a tie
                if (valid_q[0] && (!valid_q[1] || (x_q[0] <= x_q[1]))) begin
                    lead_valid_d = 1'b1;
                    lead_x_d     = x_q[0];
                    lead_w_d     = size_w(type_q[0]);
                    lead_h_d     = size_h(type_q[0]);
                end else if (valid_q[1]) begin
                    lead_valid_d = 1'b1;
                    lead_x_d     = x_q[1];
                    lead_w_d     = size_w(type_q[1]);
                    lead_h_d     = size_h(type_q[1]);
                end else begin
                    lead_valid_d = 1'b0;
                    lead_x_d     = 11'h7FF;
                    lead_w_d     = 8'd0;
                    lead_h_d     = 7'd0;
                end
                if (frame_tick) begin
                    for (int i = 0; i < 2; i++) begin
                        if (valid_q[i]) begin
                            if (x_q[i] < DX_X) begin
                                valid_d[i] = 1'b0;
                            end else begin
                                x_d[i] = x_q[i] - DX_X;
                            end
                        end else begin
                            valid_d[i] = 1'b0;
                        end
                    end
                    // Spawn sees slots freed by this tick's move step
                    if (gap_cnt_q <= DX_G) begin
                        if (!valid_d[0]) begin
                            valid_d[0] = 1'b1;
                            x_d[0]     = SPAWN_X_L;
                            type_d[0]  = lfsr_q[1:0];
                            gap_cnt_d  = gap_reload_s;
                        end else if (!valid_d[1]) begin
                            valid_d[1] = 1'b1;
                            x_d[1]     = SPAWN_X_L;
                            type_d[1]  = lfsr_q[1:0];
                            gap_cnt_d  = gap_reload_s;
                        end else begin
                            gap_cnt_d  = 10'd0;
                        end
                    end else begin
                        gap_cnt_d = gap_cnt_q - DX_G;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q;
                end
            end
            default: begin
                gap_cnt_d = gap_cnt_q;
            end
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q      <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                x_q[i]    <= 11'd0;
                type_q[i] <= 2'd0;
            end
            gap_cnt_q    <= GAP_INIT_L;
            lfsr_q       <= LFSR_SEED;
            lead_valid_q <= 1'b0;
            lead_x_q     <= 11'h7FF;
            lead_w_q     <= 8'd0;
            lead_h_q     <= 7'd0;
        end else begin
            valid_q      <= valid_d;
            x_q          <= x_d;
            type_q       <= type_d;
            gap_cnt_q    <= gap_cnt_d;
            lfsr_q       <= lfsr_d;
            lead_valid_q <= lead_valid_d;
            lead_x_q     <= lead_x_d;
            lead_w_q     <= lead_w_d;
            lead_h_q     <= lead_h_d;
        end
    end

    assign obs0_valid = valid_q[0];
    assign obs0_x     = x_q[0];
    assign obs0_type  = type_q[0];
    assign obs1_valid = valid_q[1];
    assign obs1_x     = x_q[1];
    assign obs1_type  = type_q[1];
    assign lead_valid = lead_valid_q;
    assign lead_x     = lead_x_q;
    assign lead_w     = lead_w_q;
    assign lead_h     = lead_h_q;

endmodule

// File: doc/obstacle_scheduler.md
# obstacle_scheduler

Generates the obstacle stream for the runner game: owns two obstacle slots, advances their X positions once per frame, and spawns new obstacles at pseudo-random gaps with pseudo-random types. It sits directly upstream of the obstacle renderer and the collision detector. It is driven by the game-state FSM and the 60 Hz frame tick. It emits per-slot position/type and the "lead" (nearest) obstacle's position and size.

## Interface
- SPAWN_X, 680: X at which a new obstacle appears (off-screen right, screen is 640 wide).
- DX, 5: pixels moved per frame tick.
- GAP_INIT, 300: gap counter value after leaving IDLE.
- MIN_GAP, 200: minimum spawn gap in pixels.
- GAP_MASK, 255: mask applied to the LFSR for the random gap extension.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- frame_tick  in  1  one-clk pulse per frame, synchronous to clk.
- game_state  in  2  00 IDLE, 01 RUN, 10 DEAD, 11 treated as DEAD.
- obs0_valid, obs1_valid  out  1  slot occupied.
- obs0_x, obs1_x  out  11  slot left-edge X.
- obs0_type, obs1_type  out  2  00 small cactus, 01 large cactus, 10 cactus cluster, 11 bird.
- lead_valid  out  1  at least one slot occupied.
- lead_x  out  11  X of the valid slot with smallest X.
- lead_w  out  8  width of the lead obstacle.
- lead_h  out  7  height of the lead obstacle.

## Operation
- Size table, as type → W×H: 00 → 17×35, 01 → 25×50, 10 → 51×50, 11 → 46×40.
- LFSR
  - 16-bit Fibonacci, taps 16,14,13,11, reset value 16'hACE1.
  - Advances every clk in all states, so the sequence depends on player timing.
  - Never reaches zero.
- Mode is decoded directly from game_state each cycle; there is no internal state register beyond the slots and counters.
- IDLE
  - Both slots are invalid, with x=0 and type=0.
  - gap_cnt=GAP_INIT.
  - frame_tick is ignored.
- RUN, on each frame_tick, in this order:
  - Move: for each valid slot, if x < DX the slot becomes invalid, else x ← x−DX.
  - Spawn check, using the pre-decrement gap_cnt:
    - If gap_cnt ≤ DX and a slot is free after the move step, spawn into the lowest-index free slot: x=SPAWN_X, type=lfsr[1:0], valid=1.
    - Then reload gap_cnt = MIN_GAP + (lfsr[15:8] & GAP_MASK).
  - Gap decrement:
    - Otherwise, if gap_cnt > DX, then gap_cnt ← gap_cnt−DX.
    - If gap_cnt ≤ DX and no slot is free, gap_cnt ← 0 and the spawn is retried every tick until a slot frees.
  - A slot freed by despawn on a tick is usable for spawn on the same tick.
- DEAD: all slots, gap_cnt and lead outputs hold. frame_tick is ignored.
- DEAD→IDLE clears as IDLE. IDLE→RUN starts from the cleared state.
- gap_cnt is 10 bits. MIN_GAP+GAP_MASK must be < 1024; this is a parameter legality rule, and no wrap is required.
- Lead selection
  - The lead is the valid slot with the smallest x. On a tie, slot 0 wins.
  - With no valid slot: lead_valid=0, lead_x=11'h7FF, lead_w=0, lead_h=0.

## Timing
- Reset, rst low at a clk edge:
  - All valid=0, x=0, type=0.
  - lead_valid=0, lead_x=11'h7FF, lead_w=0, lead_h=0.
  - gap_cnt=GAP_INIT, LFSR=16'hACE1.
- Slot outputs update at the clk edge that samples frame_tick=1. They are registered, with 1-cycle latency.
- Lead outputs are registered from the slot registers, so they update 1 cycle after the slots (2 cycles after the frame_tick edge).
- Reset mid-RUN clears everything on that edge and takes priority over frame_tick.
- frame_tick asserted for more than 1 cycle counts once per high cycle. Upstream guarantees single-cycle pulses.
- A game_state change and frame_tick in the same cycle: the new game_state governs that cycle.

## Test plan
- First spawn:
  - Stimulus: reset, set game_state=01, apply 60 frame_ticks.
  - Response: obs0_valid rises after the 60th tick with obs0_x=680, and obs1_valid=0. lead_x=680 two cycles after the tick, with lead_w/lead_h matching obs0_type.
- Despawn:
  - Stimulus: from the first spawn, apply 136 further ticks, then 1 more.
  - Response: obs0_x=0 after 136 ticks. obs0_valid=0 after the next tick.
- Slot exhaustion:
  - Stimulus: force MIN_GAP=0, GAP_MASK=0, DX=5.
  - Response: both slots fill on consecutive ticks, and gap_cnt holds at 0 with no third spawn. A spawn occurs on the same tick a slot despawns.
- Freeze:
  - Stimulus: mid-RUN with two valid slots, switch to game_state=10 and apply 50 ticks.
  - Response: all outputs unchanged.
- Restart:
  - Stimulus: switch 10→00.
  - Response: on the next edge both slots are invalid, lead_x=11'h7FF, and gap_cnt=300.
- Reset priority:
  - Stimulus: pull rst low in the same cycle as frame_tick during RUN.
  - Response: all outputs at their reset values next cycle, and the LFSR reads 16'hACE1.
- LFSR:
  - Stimulus: run 65535 clks.
  - Response: the state never equals 0 and returns to 16'hACE1 exactly at cycle 65535.
